// File: rtl/uart_param.sv
// Generic FIFO: first-word fall-through, registered full/empty flags.
// Latency: a write is visible at rd_dat one clk later; a read advances the head one clk later.
// Backpressure: wr ignored when full unless rd is in the same cycle; rd ignored when empty.
module uart_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] wr_dat,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic          wr_en, rd_en;

    assign wr_en  = wr && (!full || rd);
    assign rd_en  = rd && !empty;
    assign wr_nxt = wr_ptr + AW'(1);
    assign rd_nxt = rd_ptr + AW'(1);
    // Gate the head so the outputs read zero whenever nothing is stored.
    assign rd_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_nxt;
            if (rd_en) rd_ptr <= rd_nxt;
            if (wr_en && !rd_en) begin
                empty <= 1'b0;
                full  <= (wr_nxt == rd_ptr);
            end else if (rd_en && !wr_en) begin
                full  <= 1'b0;
                empty <= (rd_nxt == wr_ptr);
            end
        end
    end
endmodule

// Full-duplex UART with runtime baud divisor and parity, TX/RX FIFOs and per-byte error flags.
// Latency: TX frame starts at the first baud tick after a write; RX byte visible 1 clk after the stop sample.
// Backpressure: wr_uart ignored while tx_full; RX frames dropped (overrun set) while the RX FIFO is full.
module uart_param #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [10:0]     dvsr,
    input  logic [1:0]      par_mode,
    input  logic            wr_uart,
    input  logic [DBIT-1:0] w_data,
    output logic            tx_full,
    output logic            tx,
    input  logic            rx,
    input  logic            rd_uart,
    output logic            rx_empty,
    output logic [DBIT-1:0] r_data,
    output logic            r_perr,
    output logic            r_ferr,
    output logic            overrun,
    input  logic            clr_err
);
    localparam int SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);
    localparam logic [SW-1:0] S_LAST = SW'(15);
    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [10:0] b_cnt, dvsr_lat;
    logic        tick;
    logic        par_on, par_odd;

    assign par_on  = (par_mode == 2'b01) || (par_mode == 2'b10);
    assign par_odd = (par_mode == 2'b10);

    // A new divisor only takes effect at the wrap, so a period is never cut short.
    assign tick = (b_cnt == dvsr_lat);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_cnt    <= '0;
            dvsr_lat <= '0;
        end else if (tick) begin
            b_cnt    <= '0;
            dvsr_lat <= dvsr;
        end else begin
            b_cnt    <= b_cnt + 11'd1;
        end
    end

    state_t          tx_state;
    logic [SW-1:0]   tx_s;
    logic [2:0]      tx_n;
    logic [DBIT-1:0] tx_b, tx_head;
    logic            tx_par, tx_par_on, tx_reg, tx_empty, tx_load;

    uart_fifo #(.W(DBIT), .AW(FIFO_W)) tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr_uart),
        .rd     (tx_load),
        .wr_dat (w_data),
        .rd_dat (tx_head),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    // Loading straight from the last stop tick keeps consecutive frames gap-free.
    assign tx_load = tick && !tx_empty &&
                     ((tx_state == IDLE) || ((tx_state == STOP) && (tx_s == S_STOP)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state  <= IDLE;
            tx_s      <= '0;
            tx_n      <= '0;
            tx_b      <= '0;
            tx_par    <= 1'b0;
            tx_par_on <= 1'b0;
            tx_reg    <= 1'b1;
        end else if (tx_load) begin
            tx_state  <= START;
            tx_s      <= '0;
            tx_b      <= tx_head;
            tx_par    <= par_odd ? ~^tx_head : ^tx_head;
            tx_par_on <= par_on;
            tx_reg    <= 1'b0;
        end else if (tick) begin
            case (tx_state)
                IDLE: tx_reg <= 1'b1;
                START: begin
                    if (tx_s == S_LAST) begin
                        tx_state <= DATA;
                        tx_s     <= '0;
                        tx_n     <= '0;
                        tx_reg   <= tx_b[0];
                    end else begin
                        tx_s <= tx_s + SW'(1);
                    end
                end
                DATA: begin
                    if (tx_s == S_LAST) begin
                        tx_s <= '0;
                        tx_b <= tx_b >> 1;
                        if (tx_n == N_LAST) begin
                            if (tx_par_on) begin
                                tx_state <= PARITY;
                                tx_reg   <= tx_par;
                            end else begin
                                tx_state <= STOP;
                                tx_reg   <= 1'b1;
                            end
                        end else begin
                            tx_n   <= tx_n + 3'd1;
                            tx_reg <= tx_b[1];
                        end
                    end else begin
                        tx_s <= tx_s + SW'(1);
                    end
                end
                PARITY: begin
                    if (tx_s == S_LAST) begin
                        tx_state <= STOP;
                        tx_s     <= '0;
                        tx_reg   <= 1'b1;
                    end else begin
                        tx_s <= tx_s + SW'(1);
                    end
                end
                STOP: begin
                    if (tx_s == S_STOP) begin
                        tx_state <= IDLE;
                        tx_reg   <= 1'b1;
                    end else begin
                        tx_s <= tx_s + SW'(1);
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    assign tx = tx_reg;

    state_t          rx_state;
    logic [SW-1:0]   rx_s;
    logic [2:0]      rx_n;
    logic [DBIT-1:0] rx_b;
    logic            rx_perr, rx_wr, rx_full, rx_exp_par;
    logic [DBIT+1:0] rx_wdat, rx_head;

    assign rx_exp_par = par_odd ? ~^rx_b : ^rx_b;
    assign rx_wr      = tick && (rx_state == STOP) && (rx_s == S_STOP);
    assign rx_wdat    = {~rx, rx_perr, rx_b};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
            rx_perr  <= 1'b0;
        end else begin
            case (rx_state)
                IDLE: begin
                    if (!rx) begin
                        rx_state <= START;
                        rx_s     <= '0;
                        rx_perr  <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_s == S_MID) begin
                            rx_state <= rx ? IDLE : DATA;
                            rx_s     <= '0;
                            rx_n     <= '0;
                        end else begin
                            rx_s <= rx_s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (rx_s == S_LAST) begin
                            rx_s <= '0;
                            rx_b <= {rx, rx_b[DBIT-1:1]};
                            if (rx_n == N_LAST) rx_state <= par_on ? PARITY : STOP;
                            else                rx_n     <= rx_n + 3'd1;
                        end else begin
                            rx_s <= rx_s + SW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        if (rx_s == S_LAST) begin
                            rx_perr  <= rx ^ rx_exp_par;
                            rx_state <= STOP;
                            rx_s     <= '0;
                        end else begin
                            rx_s <= rx_s + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (rx_s == S_STOP) rx_state <= IDLE;
                        else                rx_s     <= rx_s + SW'(1);
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    uart_fifo #(.W(DBIT + 2), .AW(FIFO_W)) rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (rx_wr),
        .rd     (rd_uart),
        .wr_dat (rx_wdat),
        .rd_dat (rx_head),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    assign {r_ferr, r_perr, r_data} = rx_head;

    // A read in the same cycle frees the slot, so only a truly dropped frame counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              overrun <= 1'b0;
        else if (rx_wr && rx_full && !rd_uart)   overrun <= 1'b1;
        else if (clr_err)                        overrun <= 1'b0;
    end
endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: scoreboard queue of expected RX entries checked by a monitor.
module tb_uart_param;
    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] dvsr;
    logic [1:0]  par_mode;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        tx_full, tx, rx_line, rd_uart, rx_empty;
    logic [7:0]  r_data;
    logic        r_perr, r_ferr, overrun, clr_err;
    logic        rx_drv, loop, auto_rd;

    int vecs = 0;
    int errs = 0;
    int tcur;
    logic [9:0] exp_q[$];
    bit exp_tx [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};

    always #5 clk = ~clk;
    assign rx_line = loop ? tx : rx_drv;

    uart_param #(.DBIT(8), .SB_TICK(16), .FIFO_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .dvsr     (dvsr),
        .par_mode (par_mode),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .tx_full  (tx_full),
        .tx       (tx),
        .rx       (rx_line),
        .rd_uart  (rd_uart),
        .rx_empty (rx_empty),
        .r_data   (r_data),
        .r_perr   (r_perr),
        .r_ferr   (r_ferr),
        .overrun  (overrun),
        .clr_err  (clr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr_byte(input logic [7:0] d);
        @(posedge clk); #1;
        w_data = d; wr_uart = 1'b1;
        @(posedge clk); #1;
        wr_uart = 1'b0;
    endtask

    // One serial bit on rx_drv at 16 clk/bit (dvsr = 0).
    task automatic rx_bit(input logic b);
        @(posedge clk); #1;
        rx_drv = b;
        repeat (15) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par, input logic stop);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(d[i]);
        if (use_par) rx_bit(par);
        rx_bit(stop);
        @(posedge clk); #1;
        rx_drv = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    task automatic goto(input int target);
        while (tcur < target) begin
            @(negedge clk);
            tcur++;
        end
    endtask

    // Monitor: pops one scoreboard entry per byte presented and acknowledges it.
    initial begin
        logic [9:0] e;
        rd_uart = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_rd && reset && !rx_empty) begin
                if (exp_q.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_rx: got %h expected none", {r_ferr, r_perr, r_data});
                end else begin
                    e = exp_q.pop_front();
                    check("rx_entry", {r_ferr, r_perr, r_data}, e);
                end
                rd_uart = 1'b1;
                @(posedge clk); #1;
                rd_uart = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int lows;
        reset = 1'b0; dvsr = 11'd1; par_mode = 2'b01; wr_uart = 1'b0; w_data = '0;
        rx_drv = 1'b1; loop = 1'b0; clr_err = 1'b0; auto_rd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_tx_full", tx_full, 0);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_r_data", r_data, 0);
        check("rst_r_perr", r_perr, 0);
        check("rst_r_ferr", r_ferr, 0);
        check("rst_overrun", overrun, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // dvsr=1, even parity, 0xA5: 32 clk per bit, 352 clk frame
        wr_byte(8'hA5);
        check("t1_tx_full", tx_full, 0);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t1_start_seen", tx, 0);
        tcur = 0;
        for (int k = 0; k < 11; k++) begin
            goto(32 * k + 1);
            check($sformatf("t1_bit%0d_head", k), tx, exp_tx[k]);
            goto(32 * k + 30);
            check($sformatf("t1_bit%0d_tail", k), tx, exp_tx[k]);
        end
        goto(354);
        check("t1_idle_after", tx, 1);
        check("t1_tx_full_end", tx_full, 0);

        // loopback, odd parity
        dvsr = 11'd0; par_mode = 2'b10; loop = 1'b1; auto_rd = 1'b1;
        repeat (40) @(posedge clk);
        exp_q.push_back({2'b00, 8'h00});
        exp_q.push_back({2'b00, 8'hFF});
        exp_q.push_back({2'b00, 8'h3C});
        wr_byte(8'h00);
        wr_byte(8'hFF);
        wr_byte(8'h3C);
        wait_drain(2000);
        check("t2_rx_empty", rx_empty, 1);
        loop = 1'b0;
        repeat (20) @(posedge clk);

        // even parity: wrong parity bit, then forced-low stop bit
        par_mode = 2'b01;
        exp_q.push_back({2'b01, 8'h55});
        send_frame(8'h55, 1'b1, 1'b1, 1'b1);
        exp_q.push_back({2'b10, 8'h81});
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        wait_drain(400);
        check("t3_rx_empty", rx_empty, 1);

        // 4-clk glitch then a good frame
        repeat (20) @(posedge clk); #1;
        rx_drv = 1'b0;
        repeat (4) @(posedge clk); #1;
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("t5_glitch_empty", rx_empty, 1);
        exp_q.push_back({2'b00, 8'h5A});
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        wait_drain(400);

        // overrun: 5 frames into a 4-deep FIFO, no reads
        auto_rd = 1'b0; par_mode = 2'b00;
        repeat (20) @(posedge clk);
        exp_q.push_back({2'b00, 8'h11});
        exp_q.push_back({2'b00, 8'h22});
        exp_q.push_back({2'b00, 8'h33});
        exp_q.push_back({2'b00, 8'h44});
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        send_frame(8'h44, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("t4_overrun_before", overrun, 0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t4_overrun_set", overrun, 1);
        check("t4_rx_not_empty", rx_empty, 0);
        @(posedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        @(negedge clk);
        check("t4_overrun_clr", overrun, 0);
        auto_rd = 1'b1;
        wait_drain(200);
        check("t4_rx_empty", rx_empty, 1);

        // reset mid-frame on both TX and RX
        auto_rd = 1'b0;
        repeat (20) @(posedge clk);
        send_frame(8'h77, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t6_rx_prefill", rx_empty, 0);
        wr_byte(8'h00);
        wr_byte(8'h00);
        @(posedge clk); #1;
        rx_drv = 1'b0;
        repeat (56) @(posedge clk);
        @(negedge clk);
        check("t6_tx_mid_frame", tx, 0);
        #2;
        reset = 1'b0;
        #1;
        check("t6_tx_async", tx, 1);
        check("t6_tx_full", tx_full, 0);
        check("t6_rx_empty", rx_empty, 1);
        check("t6_r_data", r_data, 0);
        check("t6_overrun", overrun, 0);
        repeat (3) @(posedge clk); #1;
        reset = 1'b1;
        rx_drv = 1'b1;
        auto_rd = 1'b1;
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("t6_tx_stays_idle", lows, 0);
        check("t6_rx_stays_empty", rx_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
